// File: rtl/mem_arbiter.sv
// Two-port (instruction / data) arbiter in front of a single memory port.
// Non-preemptive round-robin grant, one outstanding memory command, with
// out-of-range and timeout fault completion.
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        i_valid,
  input  logic [31:0] i_addr,
  output logic        i_ready,
  output logic [31:0] i_data_out,
  output logic        i_err,

  input  logic        d_valid,
  input  logic        d_rw,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_data_in,
  input  logic [1:0]  d_byte_half_word,
  input  logic        d_is_load_unsigned,
  output logic        d_ready,
  output logic [31:0] d_data_out,
  output logic        d_err,

  output logic        mem_valid,
  output logic        mem_rw,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data_in,
  output logic [1:0]  mem_byte_half_word,
  output logic        mem_is_load_unsigned,
  input  logic        mem_ready,
  input  logic        mem_out_of_range,
  input  logic [31:0] mem_data_out,

  output logic        busy,
  output logic        owner
);

  typedef enum logic [1:0] {IDLE, SERVE, DONE} state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_t      state_q;
  logic        last_q;      // last grant: 0 = instruction, 1 = data
  logic [15:0] cnt_q;
  logic        rw_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [1:0]  bhw_q;
  logic        uns_q;
  logic        err_q;
  logic [31:0] i_data_q;
  logic [31:0] d_data_q;

  logic        gnt_d;
  logic        ok_d;
  logic        fin_d;

  // Arbitration choice and SERVE completion conditions
  always_comb begin
    gnt_d = d_valid;
    if (i_valid && d_valid) begin
      gnt_d = ~last_q;
    end
    ok_d  = mem_ready && !mem_out_of_range;
    fin_d = mem_out_of_range || mem_ready || (cnt_q == TMO_LAST);
  end

  // Arbiter FSM: grant/latch in IDLE, wait for memory in SERVE, pulse in DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      cnt_q    <= '0;
      rw_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      bhw_q    <= '0;
      uns_q    <= 1'b0;
      err_q    <= 1'b0;
      i_data_q <= '0;
      d_data_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (i_valid || d_valid) begin
            state_q <= SERVE;
            last_q  <= gnt_d;
            cnt_q   <= '0;
            if (gnt_d) begin
              rw_q    <= d_rw;
              addr_q  <= d_addr;
              wdata_q <= d_data_in;
              bhw_q   <= d_byte_half_word;
              uns_q   <= d_is_load_unsigned;
            end else begin
              rw_q    <= 1'b0;
              addr_q  <= i_addr;
              wdata_q <= '0;
              bhw_q   <= '0;
              uns_q   <= 1'b0;
            end
          end
        end
        SERVE: begin
          cnt_q <= cnt_q + 16'd1;
          if (fin_d) begin
            state_q <= DONE;
            err_q   <= ~ok_d;
            if (last_q) begin
              d_data_q <= ok_d ? mem_data_out : '0;
            end else begin
              i_data_q <= ok_d ? mem_data_out : '0;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy                 = (state_q != IDLE);
  assign owner                = last_q;

  assign mem_valid            = (state_q == SERVE);
  assign mem_rw               = rw_q;
  assign mem_addr             = addr_q;
  assign mem_data_in          = wdata_q;
  assign mem_byte_half_word   = bhw_q;
  assign mem_is_load_unsigned = uns_q;

  assign i_ready    = (state_q == DONE) && !last_q;
  assign i_err      = i_ready && err_q;
  assign i_data_out = i_data_q;

  assign d_ready    = (state_q == DONE) && last_q;
  assign d_err      = d_ready && err_q;
  assign d_data_out = d_data_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected responses,
// a memory model checks commands, and a monitor checks every ready pulse.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid;
  logic [31:0] i_addr;
  logic        i_ready;
  logic [31:0] i_data_out;
  logic        i_err;
  logic        d_valid;
  logic        d_rw;
  logic [31:0] d_addr;
  logic [31:0] d_data_in;
  logic [1:0]  d_byte_half_word;
  logic        d_is_load_unsigned;
  logic        d_ready;
  logic [31:0] d_data_out;
  logic        d_err;
  logic        mem_valid;
  logic        mem_rw;
  logic [31:0] mem_addr;
  logic [31:0] mem_data_in;
  logic [1:0]  mem_byte_half_word;
  logic        mem_is_load_unsigned;
  logic        mem_ready = 1'b0;
  logic        mem_out_of_range = 1'b0;
  logic [31:0] mem_data_out = 32'hFFFF_FFFF;
  logic        busy;
  logic        owner;

  mem_arbiter #(.TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .i_valid(i_valid), .i_addr(i_addr), .i_ready(i_ready),
    .i_data_out(i_data_out), .i_err(i_err),
    .d_valid(d_valid), .d_rw(d_rw), .d_addr(d_addr), .d_data_in(d_data_in),
    .d_byte_half_word(d_byte_half_word), .d_is_load_unsigned(d_is_load_unsigned),
    .d_ready(d_ready), .d_data_out(d_data_out), .d_err(d_err),
    .mem_valid(mem_valid), .mem_rw(mem_rw), .mem_addr(mem_addr),
    .mem_data_in(mem_data_in), .mem_byte_half_word(mem_byte_half_word),
    .mem_is_load_unsigned(mem_is_load_unsigned), .mem_ready(mem_ready),
    .mem_out_of_range(mem_out_of_range), .mem_data_out(mem_data_out),
    .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          port;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    bit          rw;
    logic [1:0]  bhw;
    bit          uns;
    bit          err;
    int          rdy;
  } exp_t;

  localparam int M_NONE  = 0;
  localparam int M_READY = 1;
  localparam int M_OOR   = 2;
  localparam int M_BOTH  = 3;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          mode = M_READY;
  int          lat = 1;
  int          srv_cnt = 0;
  logic [31:0] last_i = '0;
  logic [31:0] last_d = '0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'hA5A5_5A5A;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: checks the command each SERVE cycle and responds after lat cycles
  always @(negedge clk) begin
    if (mem_valid && !rst) begin
      srv_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL mem_cmd: mem_valid high with no expected transaction (cycle %0d)", cyc);
      end else begin
        chk("mem_addr", mem_addr, exp_q[0].addr);
        chk("mem_rw", mem_rw, exp_q[0].rw);
        chk("mem_data_in", mem_data_in, exp_q[0].wdata);
        chk("mem_bhw", mem_byte_half_word, exp_q[0].bhw);
        chk("mem_uns", mem_is_load_unsigned, exp_q[0].uns);
      end
      mem_ready        = (mode == M_READY || mode == M_BOTH) && srv_cnt == lat;
      mem_out_of_range = (mode == M_OOR || mode == M_BOTH) && srv_cnt == lat;
      mem_data_out     = mem_ready ? memf(mem_addr) : 32'hFFFF_FFFF;
    end else begin
      srv_cnt          = 0;
      mem_ready        = 1'b0;
      mem_out_of_range = 1'b0;
      mem_data_out     = 32'hFFFF_FFFF;
    end
  end

  // Response monitor: pops the scoreboard on every ready pulse
  always @(negedge clk) begin
    if (rst) begin
      last_i = '0;
      last_d = '0;
    end else if (i_ready || d_ready) begin
      chk("single_ready", i_ready && d_ready, 0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready: i_ready=%0b d_ready=%0b (cycle %0d)", i_ready, d_ready, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("port", d_ready, mon_e.port);
        chk("owner", owner, mon_e.port);
        chk("busy_done", busy, 1);
        chk("mem_valid_done", mem_valid, 0);
        if (d_ready) begin
          chk("d_data", d_data_out, mon_e.rdata);
          chk("d_err", d_err, mon_e.err);
          chk("i_err_other", i_err, 0);
          chk("i_data_hold", i_data_out, last_i);
          last_d = mon_e.rdata;
        end else begin
          chk("i_data", i_data_out, mon_e.rdata);
          chk("i_err", i_err, mon_e.err);
          chk("d_err_other", d_err, 0);
          chk("d_data_hold", d_data_out, last_d);
          last_i = mon_e.rdata;
        end
        if (mon_e.rdy >= 0) chk("latency", cyc, mon_e.rdy);
      end
    end
  end

  task automatic push(input bit port, input logic [31:0] addr, input logic [31:0] wdata,
                      input bit rw, input logic [1:0] bhw, input bit uns,
                      input bit err, input int rdy);
    exp_t e;
    e.port  = port;
    e.addr  = addr;
    e.wdata = port ? wdata : '0;
    e.rw    = port ? rw : 1'b0;
    e.bhw   = port ? bhw : 2'b00;
    e.uns   = port ? uns : 1'b0;
    e.err   = err;
    e.rdata = err ? '0 : memf(addr);
    e.rdy   = rdy;
    exp_q.push_back(e);
  endtask

  task automatic wait_rdy(input bit p);
    bit seen = 1'b0;
    for (int n = 0; n < 100 && !seen; n++) begin
      @(negedge clk);
      seen = p ? d_ready : i_ready;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s_ready_timeout: no ready within 100 cycles", p ? "d" : "i");
    end
  endtask

  task automatic run_i(input logic [31:0] addr, input bit drop);
    i_valid = 1'b1;
    i_addr  = addr;
    wait_rdy(1'b0);
    if (drop) i_valid = 1'b0;
  endtask

  task automatic run_d(input logic [31:0] addr, input logic [31:0] wdata, input bit rw,
                       input logic [1:0] bhw, input bit uns, input bit drop);
    d_valid            = 1'b1;
    d_addr             = addr;
    d_data_in          = wdata;
    d_rw               = rw;
    d_byte_half_word   = bhw;
    d_is_load_unsigned = uns;
    wait_rdy(1'b1);
    if (drop) d_valid = 1'b0;
  endtask

  // One isolated request from IDLE; k = SERVE cycles until completion
  task automatic single(input bit port, input logic [31:0] addr, input logic [31:0] wdata,
                        input bit rw, input logic [1:0] bhw, input bit uns,
                        input int m_mode, input int m_lat, input bit err, input int k);
    @(negedge clk);
    mode = m_mode;
    lat  = m_lat;
    push(port, addr, wdata, rw, bhw, uns, err, cyc + 1 + k);
    if (port) run_d(addr, wdata, rw, bhw, uns, 1'b1);
    else      run_i(addr, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    i_valid = 1'b0; i_addr = '0;
    d_valid = 1'b0; d_rw = 1'b0; d_addr = '0; d_data_in = '0;
    d_byte_half_word = 2'b00; d_is_load_unsigned = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_mem_valid", mem_valid, 0);
    chk("rst_i_ready", i_ready, 0);
    chk("rst_d_ready", d_ready, 0);
    chk("rst_i_err", i_err, 0);
    chk("rst_d_err", d_err, 0);
    chk("rst_i_data", i_data_out, 0);
    chk("rst_d_data", d_data_out, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_rw", mem_rw, 0);
    chk("rst_owner", owner, 1);
    rst = 1'b0;

    // Both ports continuously valid: instruction first, then strict alternation
    @(negedge clk);
    mode = M_READY;
    lat  = 1;
    push(0, 32'h0000_1000, '0, 0, 2'b00, 0, 0, -1);
    push(1, 32'h0000_2000, '0, 0, 2'b00, 0, 0, -1);
    push(0, 32'h0000_1004, '0, 0, 2'b00, 0, 0, -1);
    push(1, 32'h0000_2004, 32'h1122_3344, 1, 2'b11, 0, 0, -1);
    push(0, 32'h0000_1008, '0, 0, 2'b00, 0, 0, -1);
    push(1, 32'h0000_2009, '0, 0, 2'b10, 1, 0, -1);
    fork
      begin
        run_i(32'h0000_1000, 1'b0);
        run_i(32'h0000_1004, 1'b0);
        run_i(32'h0000_1008, 1'b1);
      end
      begin
        run_d(32'h0000_2000, '0, 1'b0, 2'b00, 1'b0, 1'b0);
        run_d(32'h0000_2004, 32'h1122_3344, 1'b1, 2'b11, 1'b0, 1'b0);
        run_d(32'h0000_2009, '0, 1'b0, 2'b10, 1'b1, 1'b1);
      end
    join

    single(1, 32'h0000_0100, 32'hDEAD_BEEF, 1, 2'b00, 0, M_READY, 3, 0, 3);
    single(1, 32'h0000_0202, '0, 0, 2'b01, 1, M_READY, 2, 0, 2);
    single(0, 32'h0001_0000, '0, 0, 2'b00, 0, M_OOR, 1, 1, 1);
    single(1, 32'h0000_0300, '0, 0, 2'b00, 0, M_NONE, 0, 1, 8);
    single(1, 32'h0000_0304, '0, 0, 2'b00, 0, M_READY, 8, 0, 8);
    single(0, 32'h0000_0400, '0, 0, 2'b00, 0, M_BOTH, 2, 1, 2);
    single(1, 32'h0000_0500, 32'h55AA_33CC, 1, 2'b10, 0, M_OOR, 3, 1, 3);

    // Reset in the second SERVE cycle abandons the transaction
    @(negedge clk);
    mode = M_NONE;
    push(1, 32'h0000_0600, '0, 0, 2'b00, 0, 0, -1);
    d_valid = 1'b1; d_addr = 32'h0000_0600; d_rw = 1'b0; d_data_in = '0;
    d_byte_half_word = 2'b00; d_is_load_unsigned = 1'b0;
    for (int n = 0; n < 10 && !mem_valid; n++) @(negedge clk);
    chk("abort_serve", mem_valid, 1);
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    d_valid = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_mem_valid", mem_valid, 0);
    chk("abort_d_ready", d_ready, 0);
    chk("abort_i_ready", i_ready, 0);
    chk("abort_d_err", d_err, 0);
    chk("abort_mem_addr", mem_addr, 0);
    chk("abort_d_data", d_data_out, 0);
    chk("abort_i_data", i_data_out, 0);
    chk("abort_owner", owner, 1);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    single(1, 32'h0000_0700, '0, 0, 2'b00, 0, M_READY, 1, 0, 1);
    single(0, 32'h0000_0704, '0, 0, 2'b00, 0, M_READY, 2, 0, 2);

    repeat (3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
